// File: rtl/syscall_unit_if.sv
// syscall_unit_if: request, pipeline-control, memory-read and byte-stream
// signals shared between the syscall unit and the rest of the core.
//
// Byte stream handshake: the producer raises out_valid with out_data and
// holds both unchanged until a rising edge where out_valid & out_ready are
// both high; that edge is the transfer. out_ready may toggle freely and has
// no effect while out_valid is low.
interface syscall_unit_if;
    logic        sys_req;
    logic [31:0] regv;
    logic [31:0] rega;
    logic        stall;
    logic        busy;
    logic        halt;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    // Pipeline, memory and console side.
    modport master (
        output sys_req, regv, rega, mem_rdata, out_ready,
        input  stall, busy, halt, mem_rd, mem_addr, out_valid, out_data
    );

    // The syscall unit itself.
    modport slave (
        input  sys_req, regv, rega, mem_rdata, out_ready,
        output stall, busy, halt, mem_rd, mem_addr, out_valid, out_data
    );
endinterface

// File: rtl/syscall_unit.sv
// syscall_unit: services syscalls retired in writeback. Print char (11),
// print string (4), exit (10) and, when SYSCALL_PRINT_INT_EN is defined,
// print signed int (1). Other codes are a one-cycle no-op. Without
// SYSCALL_PRINT_INT_EN, code 1 also takes the no-op path.
// dbgState exposes the FSM state for debug and checkers.
module syscall_unit #(
    parameter int DIGITS = 10
) (
    input  logic           clk,
    input  logic           reset,
    syscall_unit_if.slave  bus,
    output logic [3:0]     dbgState
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CHAR       = 4'd1,
        STR_RD     = 4'd2,
        STR_WAIT   = 4'd3,
        STR_OUT    = 4'd4,
        INT_CONV   = 4'd5,
        INT_EMIT   = 4'd6,
        NOP        = 4'd7,
        EXIT       = 4'd8
    } stateE;

    stateE       state;
    stateE       nextState;

    logic [31:0] addr;       // byte address of the next string character
    logic [7:0]  outByte;    // byte presented in CHAR / STR_OUT
    logic        haltReg;
    logic        outValid;
    logic        transfer;
    logic        startReq;
    logic [7:0]  laneByte;

`ifdef SYSCALL_PRINT_INT_EN
    localparam int CW = $clog2(DIGITS + 1);

    logic [31:0] mag;          // remaining unsigned magnitude
    logic [31:0] magNext;
    logic [3:0]  digit;
    logic        negPending;   // '-' still to be emitted
    logic [3:0]  digits [DIGITS];
    logic [CW-1:0] cnt;        // digits currently held in the buffer

    assign magNext = mag / 32'd10;
    assign digit   = 4'(mag % 32'd10);
`endif

    assign transfer = outValid & bus.out_ready;
    assign startReq = (state == IDLE) & bus.sys_req & ~haltReg;

    // Select the little-endian byte lane addressed by the low address bits.
    always_comb begin
        laneByte = 8'h00;
        case (addr[1:0])
            2'd0: laneByte = bus.mem_rdata[7:0];
            2'd1: laneByte = bus.mem_rdata[15:8];
            2'd2: laneByte = bus.mem_rdata[23:16];
            2'd3: laneByte = bus.mem_rdata[31:24];
            default: laneByte = 8'h00;
        endcase
    end

    // State register; reset abandons any service in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: dispatch on the service code, then walk the service.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (startReq) begin
                    if (bus.regv == 32'd11) begin
                        nextState = CHAR;
                    end else if (bus.regv == 32'd4) begin
                        nextState = STR_RD;
                    end else if (bus.regv == 32'd10) begin
                        nextState = EXIT;
`ifdef SYSCALL_PRINT_INT_EN
                    end else if (bus.regv == 32'd1) begin
                        nextState = INT_CONV;
`endif
                    end else begin
                        nextState = NOP;
                    end
                end
            end
            CHAR:     if (transfer) nextState = IDLE;
            STR_RD:   nextState = STR_WAIT;
            STR_WAIT: nextState = (laneByte == 8'h00) ? IDLE : STR_OUT;
            STR_OUT:  if (transfer) nextState = STR_RD;
`ifdef SYSCALL_PRINT_INT_EN
            INT_CONV: if (magNext == 32'd0) nextState = INT_EMIT;
            INT_EMIT: if (transfer && !negPending && cnt == CW'(1)) nextState = IDLE;
`endif
            NOP:      nextState = IDLE;
            EXIT:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Output decode from the current state and held datapath registers.
    always_comb begin
        outValid = 1'b0;
        bus.out_data = 8'h00;
        bus.mem_rd = 1'b0;
        case (state)
            CHAR, STR_OUT: begin
                outValid = 1'b1;
                bus.out_data = outByte;
            end
            STR_RD: bus.mem_rd = 1'b1;
`ifdef SYSCALL_PRINT_INT_EN
            INT_EMIT: begin
                outValid = 1'b1;
                bus.out_data = negPending ? 8'h2D : (8'h30 + {4'h0, digits[cnt - CW'(1)]});
            end
`endif
            default: ;
        endcase
    end

    assign bus.out_valid = outValid;
    assign bus.busy      = (state != IDLE);
    assign bus.halt      = haltReg;
    assign bus.stall     = (state != IDLE) | (bus.sys_req & ~haltReg);
    assign bus.mem_addr  = {addr[31:2], 2'b00};
    assign dbgState      = state;

    // Datapath: latch the argument on dispatch and advance per service.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= 32'd0;
            outByte    <= 8'h00;
            haltReg    <= 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
            mag        <= 32'd0;
            negPending <= 1'b0;
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (startReq) begin
                        outByte <= bus.rega[7:0];
                        if (bus.regv == 32'd4) addr <= bus.rega;
`ifdef SYSCALL_PRINT_INT_EN
                        // Unsigned negation keeps -2^31 exact as 2^31.
                        mag        <= bus.rega[31] ? (32'd0 - bus.rega) : bus.rega;
                        negPending <= bus.rega[31];
                        cnt        <= '0;
`endif
                    end
                end
                STR_WAIT: outByte <= laneByte;
                STR_OUT:  if (transfer) addr <= addr + 32'd1;
                EXIT:     haltReg <= 1'b1;
`ifdef SYSCALL_PRINT_INT_EN
                INT_CONV: begin
                    digits[cnt] <= digit;
                    cnt         <= cnt + CW'(1);
                    mag         <= magNext;
                end
                INT_EMIT: begin
                    if (transfer) begin
                        if (negPending) negPending <= 1'b0;
                        else            cnt <= cnt - CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: randomized self-checking bench for syscall_unit.
// Expected streams come from a behavioural model: memory bytes walked until
// NUL, $sformatf for decimal text, simple cycle formulas for busy length.
module tb_syscall_unit;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] dbgState;

  always #5 clk = ~clk;

  syscall_unit_if bus();

  syscall_unit #(.DIGITS(10)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .dbgState(dbgState)
  );

  int nChecks = 0;
  int nPass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [31:0] rd_q[$];
  logic [7:0] memBytes [logic [31:0]];
  int readyMode = 0;
  int holdCnt = 0;
  bit xferSeen = 1'b0;
  bit prevHeld = 1'b0;
  logic [7:0] prevData = 8'h00;
  int unstable = 0;

  function automatic logic [7:0] rdByte(input logic [31:0] a);
    return memBytes.exists(a) ? memBytes[a] : 8'h00;
  endfunction

  function automatic string q2s(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Memory model: word read, data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (bus.mem_rd)
      bus.mem_rdata <= {rdByte(bus.mem_addr + 32'd3), rdByte(bus.mem_addr + 32'd2),
                        rdByte(bus.mem_addr + 32'd1), rdByte(bus.mem_addr)};
  end

  // Consumer: always ready, 5-cycle hold per byte, or random.
  always @(posedge clk) begin
    #1;
    if (xferSeen) begin holdCnt = 0; xferSeen = 1'b0; end
    case (readyMode)
      0: bus.out_ready = 1'b1;
      1: begin
        if (bus.out_valid && holdCnt < 5) begin bus.out_ready = 1'b0; holdCnt++; end
        else bus.out_ready = 1'b1;
      end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor on the falling edge: transfers, reads, and held-byte stability.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      xferSeen = 1'b1;
    end
    if (!reset && bus.mem_rd) rd_q.push_back(bus.mem_addr);
    if (prevHeld && !reset && bus.out_valid && bus.out_data !== prevData) unstable++;
    prevHeld = !reset && bus.out_valid && !bus.out_ready;
    prevData = bus.out_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic issue(input logic [31:0] v, input logic [31:0] a, output logic stallSeen);
    @(posedge clk); #1;
    bus.sys_req = 1'b1; bus.regv = v; bus.rega = a;
    @(negedge clk);
    stallSeen = bus.stall;
    @(posedge clk); #1;
    bus.sys_req = 1'b0; bus.regv = $urandom; bus.rega = $urandom;
  endtask

  task automatic run_to_idle(output int busyCycles, output bit timedOut);
    busyCycles = 0; timedOut = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.busy) busyCycles++;
      else begin timedOut = 1'b0; break; end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.halt !== 1'b0) $display("FAIL reset_halt: got %b want 0", bus.halt); else nPass++;
    nChecks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else nPass++;
    nChecks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", bus.out_data); else nPass++;
    nChecks++; if (bus.mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); else nPass++;
    nChecks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else nPass++;
    nChecks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else nPass++;
  endtask

  task automatic test_char();
    logic st; int bc; bit to; logic [31:0] a;
    readyMode = 0; got_q.delete();
    issue(32'd11, 32'h41, st);
    run_to_idle(bc, to);
    exp_q = '{8'h41};
    nChecks++; if (st !== 1'b1) $display("FAIL char_stall: got %b want 1", st); else nPass++;
    nChecks++; if (to || bc != 1) $display("FAIL char_busy: got %0d cycles (timeout %0d) want 1", bc, to); else nPass++;
    nChecks++; if (q2s(got_q) != q2s(exp_q)) $display("FAIL char_stream: got %s want %s", q2s(got_q), q2s(exp_q)); else nPass++;
    readyMode = 2;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; got_q.delete(); exp_q = '{a[7:0]};
      issue(32'd11, a, st);
      run_to_idle(bc, to);
      nChecks++; if (to || q2s(got_q) != q2s(exp_q)) $display("FAIL char_rand: got %s want %s", q2s(got_q), q2s(exp_q)); else nPass++;
    end
  endtask

  task automatic run_string(input logic [31:0] a, input string name);
    logic st; int bc; bit to; logic [31:0] exp_rd[$]; string gr, er;
    exp_q.delete(); got_q.delete(); rd_q.delete(); unstable = 0;
    for (int i = 0; i < 64; i++) begin
      exp_rd.push_back((a + 32'(i)) & 32'hFFFF_FFFC);
      if (rdByte(a + 32'(i)) == 8'h00) break;
      exp_q.push_back(rdByte(a + 32'(i)));
    end
    issue(32'd4, a, st);
    run_to_idle(bc, to);
    gr = ""; er = "";
    foreach (rd_q[i]) gr = {gr, $sformatf("%h ", rd_q[i])};
    foreach (exp_rd[i]) er = {er, $sformatf("%h ", exp_rd[i])};
    nChecks++; if (to || q2s(got_q) != q2s(exp_q)) $display("FAIL %s_stream: got %s want %s", name, q2s(got_q), q2s(exp_q)); else nPass++;
    nChecks++; if (gr != er) $display("FAIL %s_reads: got %s want %s", name, gr, er); else nPass++;
    nChecks++; if (unstable != 0) $display("FAIL %s_stable: got %0d changes want 0", name, unstable); else nPass++;
  endtask

  task automatic test_string();
    logic [31:0] a; int len;
    memBytes.delete();
    memBytes[32'h100] = 8'h48; memBytes[32'h101] = 8'h69; memBytes[32'h102] = 8'h00;
    readyMode = 0; run_string(32'h100, "str_hi");
    readyMode = 1; run_string(32'h100, "str_hi_hold");
    readyMode = 2;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 32'hFFFF_FFFD : ($urandom & 32'h0000_FFFF);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) memBytes[a + 32'(i)] = 8'($urandom_range(1, 255));
      memBytes[a + 32'(len)] = 8'h00;
      run_string(a, "str_rand");
    end
  endtask

  task automatic test_int();
    logic st; int bc; bit to; logic [31:0] v; string s; int want;
`ifdef SYSCALL_PRINT_INT_EN
    logic [31:0] vals[$];
    vals = '{32'd0, 32'd305, 32'h8000_0000};
    for (int i = 0; i < 4; i++) vals.push_back($urandom);
    for (int k = 0; k < vals.size(); k++) begin
      v = vals[k];
      readyMode = (k < 3) ? 0 : 2;
      s = $sformatf("%0d", $signed(v));
      exp_q.delete(); got_q.delete();
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      issue(32'd1, v, st);
      run_to_idle(bc, to);
      want = 2 * s.len() - (v[31] ? 1 : 0);
      nChecks++; if (to || q2s(got_q) != q2s(exp_q)) $display("FAIL int_stream: got %s want %s", q2s(got_q), q2s(exp_q)); else nPass++;
      if (k < 3) begin
        nChecks++; if (bc != want) $display("FAIL int_busy: got %0d cycles want %0d", bc, want); else nPass++;
      end
    end
`else
    readyMode = 0; got_q.delete();
    issue(32'd1, 32'd305, st);
    run_to_idle(bc, to);
    nChecks++; if (to || bc != 1) $display("FAIL int_off_busy: got %0d cycles want 1", bc); else nPass++;
    nChecks++; if (got_q.size() != 0) $display("FAIL int_off_stream: got %0d bytes want 0", got_q.size()); else nPass++;
`endif
  endtask

  task automatic test_nop();
    logic st; int bc; bit to; logic [31:0] codes[$];
    codes = '{32'd0, 32'($urandom_range(12, 1000)), 32'd5};
    readyMode = 0;
    foreach (codes[i]) begin
      got_q.delete();
      issue(codes[i], $urandom, st);
      run_to_idle(bc, to);
      nChecks++; if (to || bc != 1 || got_q.size() != 0)
        $display("FAIL nop: code %0d got %0d cycles %0d bytes want 1 cycle 0 bytes", codes[i], bc, got_q.size());
      else nPass++;
    end
  endtask

  task automatic test_reset_mid_string();
    logic st; int nrd; bit seen;
    memBytes.delete();
    memBytes[32'h200] = 8'h48; memBytes[32'h201] = 8'h65; memBytes[32'h202] = 8'h6C;
    memBytes[32'h203] = 8'h6C; memBytes[32'h204] = 8'h6F; memBytes[32'h205] = 8'h00;
    readyMode = 0; got_q.delete(); rd_q.delete();
    issue(32'd4, 32'h200, st);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (got_q.size() >= 1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    nChecks++; if (!seen) $display("FAIL rst_mid_first_byte: got 0 bytes want 1"); else nPass++;
    pulse_reset();
    @(negedge clk);
    nChecks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.halt !== 1'b0)
      $display("FAIL rst_mid_idle: got valid %b busy %b halt %b want 0 0 0", bus.out_valid, bus.busy, bus.halt);
    else nPass++;
    nrd = rd_q.size();
    repeat (8) @(negedge clk);
    nChecks++; if (rd_q.size() != nrd) $display("FAIL rst_mid_reads: got %0d reads want %0d", rd_q.size(), nrd); else nPass++;
    nChecks++; if (got_q.size() != 1) $display("FAIL rst_mid_bytes: got %0d bytes want 1", got_q.size()); else nPass++;
  endtask

  task automatic test_exit();
    logic st; int bc; bit to;
    readyMode = 0; got_q.delete();
    issue(32'd10, $urandom, st);
    @(negedge clk);
    nChecks++; if (bus.busy !== 1'b1 || bus.halt !== 1'b0)
      $display("FAIL exit_n1: got busy %b halt %b want 1 0", bus.busy, bus.halt); else nPass++;
    @(negedge clk);
    nChecks++; if (bus.busy !== 1'b0 || bus.halt !== 1'b1)
      $display("FAIL exit_n2: got busy %b halt %b want 0 1", bus.busy, bus.halt); else nPass++;
    issue(32'd11, 32'h5A, st);
    run_to_idle(bc, to);
    repeat (5) @(negedge clk);
    nChecks++; if (st !== 1'b0) $display("FAIL halted_stall: got %b want 0", st); else nPass++;
    nChecks++; if (bc != 0 || got_q.size() != 0)
      $display("FAIL halted_ignored: got %0d busy cycles %0d bytes want 0 0", bc, got_q.size()); else nPass++;
    nChecks++; if (bus.halt !== 1'b1) $display("FAIL halt_sticky: got %b want 1", bus.halt); else nPass++;
    pulse_reset();
    @(negedge clk);
    nChecks++; if (bus.halt !== 1'b0) $display("FAIL halt_reset: got %b want 0", bus.halt); else nPass++;
  endtask

  initial begin
    reset = 1'b1;
    bus.sys_req = 1'b0; bus.regv = 32'd0; bus.rega = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_char();
    test_string();
    test_int();
    test_nop();
    test_reset_mid_string();
    test_exit();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
